serial_add_arbiter: RTL and testbench
=====================================

// Module: serial_add_arbiter
// PURPOSE
//  Shares one combinational 1-bit full-adder cell between N requesters. Grants
//  one W-bit add at a time (round-robin), streams the operands LSB-first through
//  the cell over W cycles with its own carry register, assembles the sum, and
//  returns it with cout/zero flags on a valid/ready response port.
// PARAMETERS
//  N  4  number of requesters (N >= 2)
//  W  6  operand/sum width in bits (W >= 2)
// PORTS
//  clk        in   1    clock, rising edge
//  rstn       in   1    asynchronous reset, active-low
//  req        in   N    per-requester add request; held with operands until gnt
//  opa        in   N*W  operand A, requester i at [i*W +: W]
//  opb        in   N*W  operand B, requester i at [i*W +: W]
//  gnt        out  N    one-hot; high for exactly the accept cycle
//  busy       out  1    high in SHIFT or RESP
//  fa_a       out  1    bit of A to the adder cell
//  fa_b       out  1    bit of B to the adder cell
//  fa_cin     out  1    carry-in to the adder cell
//  fa_s       in   1    sum from the cell (combinational from fa_a/fa_b/fa_cin)
//  fa_co      in   1    carry-out from the cell (combinational)
//  rsp_valid  out  1    response valid
//  rsp_ready  in   1    response accepted when rsp_valid & rsp_ready
//  rsp_id     out  clog2(N)  index of requester that owns the response
//  rsp_sum    out  W    A+B mod 2^W
//  rsp_cout   out  1    carry out of bit W-1
//  rsp_zero   out  1    rsp_sum == 0 (cout excluded)
// BEHAVIOUR
//  Reset: state IDLE; gnt=0, busy=0, fa_*=0, rsp_valid=0, rsp_id=0, rsp_sum=0,
//   rsp_cout=0, rsp_zero=0; carry=0, bit counter=0, RR pointer=0.
//  FSM IDLE -> SHIFT -> RESP -> IDLE.
//  IDLE: if |req, winner = first set req at or above pointer, wrapping; gnt is
//   combinational (req & IDLE), high that cycle only. At that edge: latch opa/opb
//   of winner into shift regs, rsp_id<=winner, carry<=0, count<=0,
//   pointer<=(winner+1)%N, go SHIFT. No req -> stay IDLE.
//  SHIFT (exactly W cycles): fa_a=shA[0], fa_b=shB[0], fa_cin=carry. Each edge:
//   sum reg shifts right with fa_s into bit W-1; carry<=fa_co; shA/shB shift
//   right; count++. On count==W-1 edge: rsp_cout<=fa_co, go RESP.
//  RESP: rsp_valid=1; rsp_sum/id/cout/zero stable while waiting. On
//   rsp_valid&rsp_ready -> IDLE (next gnt earliest the following cycle).
//  Latency: accept edge at cycle T -> rsp_valid high from cycle T+W+1.
//  fa_a/fa_b/fa_cin are 0 outside SHIFT. gnt never asserts outside IDLE; req
//   changes during SHIFT/RESP are ignored.
//  Requester must keep req/operands stable until it sees gnt and drop req the
//   cycle after; a req still high after gnt is a new request.
//  Simultaneous reqs: only the RR winner granted; others wait, none dropped.
//  Reset mid-operation: aborts instantly, no response issued, pointer back to 0.
// TESTING
//  N=4,W=6. req[0], A=25, B=13 -> gnt[0] 1 cycle; rsp_valid 7 cycles after the
//   accept edge, rsp_id=0, sum=38, cout=0, zero=0.
//  req[2], A=63, B=1 -> sum=0, cout=1, zero=1; A=0,B=0 -> sum=0, cout=0, zero=1.
//  req=4'b1111 held, rsp_ready=1 -> grants in order 0,1,2,3,0; each rsp_id matches.
//  req[1] and req[3] continuously re-asserted -> grants alternate 1,3,1,3.
//  rsp_ready=0 for 5 cycles in RESP with req[0]=1 -> rsp fields stable, no gnt,
//   fa_*=0; ready=1 -> IDLE, then gnt[0].
//  rstn low on 3rd SHIFT cycle -> all outputs 0 immediately; next add A=1,B=1
//   from req[3] -> granted (pointer 0 scan), sum=2, cout=0 (no stale carry).

Source files
------------

// File: rtl/serial_add_arbiter_if.sv
// Requester-side bus of the shared serial adder: per-requester add requests with
// operands, plus the single valid/ready response channel.
interface serial_add_arbiter_if #(
   parameter int N = 4,
   parameter int W = 6
);
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   logic [N-1:0]   req;
   logic [N*W-1:0] opa;
   logic [N*W-1:0] opb;
   logic [N-1:0]   gnt;

   // Handshake: a response transfers on any rising edge where rsp_valid and
   // rsp_ready are both high; rsp_valid never drops and rsp_* never change
   // until that edge. A request is consumed on the edge where its gnt bit is high.
   logic            rsp_valid;
   logic            rsp_ready;
   logic [IW-1:0]   rsp_id;
   logic [W-1:0]    rsp_sum;
   logic            rsp_cout;
   logic            rsp_zero;

   modport master (
      output req, opa, opb, rsp_ready,
      input  gnt, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_zero
   );

   modport slave (
      input  req, opa, opb, rsp_ready,
      output gnt, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_zero
   );
endinterface

// File: rtl/serial_add_arbiter.sv
// Round-robin arbiter that time-shares one external 1-bit full-adder cell,
// streaming a granted W-bit add LSB-first and returning sum, cout and zero.
module serial_add_arbiter #(
   parameter int N = 4,
   parameter int W = 6
) (
   input  logic                  clk,
   input  logic                  rstn,
   serial_add_arbiter_if.slave   bus,
   output logic                  busy,
   output logic                  fa_a,
   output logic                  fa_b,
   output logic                  fa_cin,
   input  logic                  fa_s,
   input  logic                  fa_co,
   output logic [1:0]            dbg_state
);
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam int CW = (W > 1) ? $clog2(W) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t         state, state_nxt;
   logic [W-1:0]   sh_a, sh_b, sum_q, sum_shift;
   logic           carry, cout_q, zero_q;
   logic [CW-1:0]  count;
   logic [IW-1:0]  ptr, winner, id_q;
   logic           found, accept, last_bit;

   // Scan from the pointer upward with wrap; iterating high-to-low offsets lets
   // the nearest requester overwrite any farther one.
   always_comb begin
      int idx;
      idx    = 0;
      winner = '0;
      found  = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = (int'(ptr) + k) % N;
         if (bus.req[idx]) begin
            winner = IW'(idx);
            found  = 1'b1;
         end
      end
   end

   assign accept   = rstn && (state == IDLE) && found;
   assign last_bit = (count == CW'(W - 1));
   assign sum_shift = {fa_s, sum_q[W-1:1]};

   always_comb begin
      bus.gnt = '0;
      if (accept) bus.gnt[winner] = 1'b1;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = SHIFT;
         SHIFT:   if (last_bit) state_nxt = RESP;
         RESP:    if (bus.rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sh_a   <= '0;
         sh_b   <= '0;
         sum_q  <= '0;
         carry  <= 1'b0;
         count  <= '0;
         ptr    <= '0;
         id_q   <= '0;
         cout_q <= 1'b0;
         zero_q <= 1'b0;
      end else if (accept) begin
         sh_a  <= bus.opa[winner*W +: W];
         sh_b  <= bus.opb[winner*W +: W];
         id_q  <= winner;
         carry <= 1'b0;
         count <= '0;
         ptr   <= (winner == IW'(N - 1)) ? '0 : winner + 1'b1;
      end else if (state == SHIFT) begin
         sum_q <= sum_shift;
         carry <= fa_co;
         sh_a  <= sh_a >> 1;
         sh_b  <= sh_b >> 1;
         count <= count + 1'b1;
         if (last_bit) begin
            cout_q <= fa_co;
            zero_q <= (sum_shift == '0);
         end
      end
   end

   // The cell sees all-zero inputs whenever no add is in flight.
   assign fa_a   = (state == SHIFT) & sh_a[0];
   assign fa_b   = (state == SHIFT) & sh_b[0];
   assign fa_cin = (state == SHIFT) & carry;

   assign busy          = (state != IDLE);
   assign bus.rsp_valid = (state == RESP);
   assign bus.rsp_id    = id_q;
   assign bus.rsp_sum   = sum_q;
   assign bus.rsp_cout  = cout_q;
   assign bus.rsp_zero  = zero_q;
   assign dbg_state     = state;
endmodule

// File: tb/tb_serial_add_arbiter.sv
// Bench for serial_add_arbiter: models the full-adder cell, records grants into a
// scoreboard queue and checks each response against an independent A+B model.
module tb_serial_add_arbiter;
   localparam int N  = 4;
   localparam int W  = 6;
   localparam int IW = 2;
   localparam int EW = IW + W + 2;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   serial_add_arbiter_if #(.N(N), .W(W)) bus ();
   logic busy, fa_a, fa_b, fa_cin, fa_s, fa_co;
   logic [1:0] dbg_state;

   assign fa_s  = fa_a ^ fa_b ^ fa_cin;
   assign fa_co = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

   serial_add_arbiter #(.N(N), .W(W)) dut (
      .clk(clk), .rstn(rstn), .bus(bus), .busy(busy),
      .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin), .fa_s(fa_s), .fa_co(fa_co),
      .dbg_state(dbg_state)
   );

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   logic [EW-1:0] exp_q[$];
   int gnt_log[$];
   logic [N-1:0] hold_mask = '0;
   logic [N-1:0] s_gnt;
   logic s_valid, s_busy, s_cout, s_zero;
   logic [2:0] s_fa;
   logic [W-1:0] s_sum;
   logic [IW-1:0] s_id;
   logic [1:0] s_state;
   int last_gnt_cyc = 0;
   int last_rsp_cyc = 0;
   logic [EW-1:0] last_rsp = '0;

   // One clock: sample at negedge, score grants/responses, drive after posedge.
   task automatic step();
      logic [EW-1:0] exp;
      logic [W:0] s;
      logic [W-1:0] a, b;
      logic [N-1:0] drop;
      int idx;
      @(negedge clk);
      cyc++;
      s_gnt = bus.gnt; s_valid = bus.rsp_valid; s_busy = busy;
      s_fa = {fa_a, fa_b, fa_cin}; s_sum = bus.rsp_sum; s_id = bus.rsp_id;
      s_cout = bus.rsp_cout; s_zero = bus.rsp_zero; s_state = dbg_state;
      drop = '0;
      if (s_gnt !== '0) begin
         tests++;
         if ($countones(s_gnt) != 1 || s_state !== 2'd0) begin
            fails++;
            $display("FAIL gnt_onehot: gnt=%b state=%0d, required one-hot in IDLE", s_gnt, s_state);
         end
         idx = 0;
         for (int i = 0; i < N; i++) if (s_gnt[i]) idx = i;
         a = bus.opa[idx*W +: W];
         b = bus.opb[idx*W +: W];
         s = {1'b0, a} + {1'b0, b};
         exp = {IW'(idx), s[W-1:0], s[W], (s[W-1:0] == '0)};
         exp_q.push_back(exp);
         gnt_log.push_back(idx);
         last_gnt_cyc = cyc;
         drop = s_gnt;
      end
      if (s_valid && bus.rsp_ready) begin
         tests++;
         last_rsp = {s_id, s_sum, s_cout, s_zero};
         last_rsp_cyc = cyc;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL rsp_unexpected: got id/sum/cout/zero=%h, required no response", last_rsp);
         end else begin
            exp = exp_q.pop_front();
            if (last_rsp !== exp) begin
               fails++;
               $display("FAIL rsp_scoreboard: got id/sum/cout/zero=%h, required %h", last_rsp, exp);
            end
         end
      end
      @(posedge clk);
      #1;
      bus.req = bus.req & ~(drop & ~hold_mask);
   endtask

   task automatic start_add(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
      bus.opa[idx*W +: W] = a;
      bus.opb[idx*W +: W] = b;
      bus.req[idx] = 1'b1;
   endtask

   task automatic wait_gnt(input int budget);
      for (int i = 0; i < budget; i++) begin
         step();
         if (s_gnt !== '0) return;
      end
      tests++; fails++;
      $display("FAIL wait_gnt: no grant within %0d cycles", budget);
   endtask

   task automatic wait_rsp(input int budget);
      int c0;
      c0 = last_rsp_cyc;
      for (int i = 0; i < budget; i++) begin
         step();
         if (last_rsp_cyc != c0) return;
      end
      tests++; fails++;
      $display("FAIL wait_rsp: no response within %0d cycles", budget);
   endtask

   task automatic wait_idle(input int budget);
      for (int i = 0; i < budget; i++) begin
         step();
         if (exp_q.size() == 0 && bus.req == '0 && !s_busy) return;
      end
      tests++; fails++;
      $display("FAIL wait_idle: %0d responses outstanding after %0d cycles", exp_q.size(), budget);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rstn = 1'b0;
      bus.req = '0;
      exp_q.delete();
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      bus.req = 4'b1111;
      bus.rsp_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      tests++;
      if (bus.gnt !== 4'b0000) begin fails++; $display("FAIL reset_gnt: got %b, required 0000", bus.gnt); end
      tests++;
      if ({busy, bus.rsp_valid} !== 2'b00) begin fails++; $display("FAIL reset_busy_valid: got %b, required 00", {busy, bus.rsp_valid}); end
      tests++;
      if ({fa_a, fa_b, fa_cin} !== 3'b000) begin fails++; $display("FAIL reset_fa: got %b, required 000", {fa_a, fa_b, fa_cin}); end
      tests++;
      if ({bus.rsp_id, bus.rsp_sum, bus.rsp_cout, bus.rsp_zero} !== '0) begin
         fails++; $display("FAIL reset_rsp: got %h, required 0", {bus.rsp_id, bus.rsp_sum, bus.rsp_cout, bus.rsp_zero});
      end
      tests++;
      if (dbg_state !== 2'd0) begin fails++; $display("FAIL reset_state: got %0d, required 0", dbg_state); end
      bus.req = '0;
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_basic();
      int g;
      gnt_log.delete();
      start_add(0, 6'd25, 6'd13);
      wait_gnt(10);
      g = last_gnt_cyc;
      tests++;
      if (s_gnt !== 4'b0001) begin fails++; $display("FAIL basic_gnt: got %b, required 0001", s_gnt); end
      step();
      tests++;
      if (s_gnt !== 4'b0000) begin fails++; $display("FAIL basic_gnt_pulse: got %b, required 0000", s_gnt); end
      tests++;
      if (s_fa !== 3'b110) begin fails++; $display("FAIL basic_fa_bit0: got %b, required 110", s_fa); end
      for (int i = 0; i < 20 && !s_valid; i++) step();
      tests++;
      if (cyc - g != W + 1) begin fails++; $display("FAIL basic_latency: got %0d, required %0d", cyc - g, W + 1); end
      tests++;
      if ({s_id, s_sum, s_cout, s_zero} !== {2'd0, 6'd38, 1'b0, 1'b0}) begin
         fails++; $display("FAIL basic_rsp: got id=%0d sum=%0d cout=%b zero=%b, required 0/38/0/0", s_id, s_sum, s_cout, s_zero);
      end
      wait_idle(20);
   endtask

   task automatic test_carry_zero();
      start_add(2, 6'd63, 6'd1);
      wait_rsp(30);
      tests++;
      if (last_rsp !== {2'd2, 6'd0, 1'b1, 1'b1}) begin fails++; $display("FAIL wrap_rsp: got %h, required %h", last_rsp, {2'd2, 6'd0, 1'b1, 1'b1}); end
      start_add(2, 6'd0, 6'd0);
      wait_rsp(30);
      tests++;
      if (last_rsp !== {2'd2, 6'd0, 1'b0, 1'b1}) begin fails++; $display("FAIL zero_rsp: got %h, required %h", last_rsp, {2'd2, 6'd0, 1'b0, 1'b1}); end
      wait_idle(20);
   endtask

   task automatic test_round_robin();
      do_reset();
      gnt_log.delete();
      for (int i = 0; i < N; i++) begin
         bus.opa[i*W +: W] = W'($urandom_range(0, 63));
         bus.opb[i*W +: W] = W'($urandom_range(0, 63));
      end
      hold_mask = 4'b1111;
      bus.req = 4'b1111;
      for (int i = 0; i < 100 && gnt_log.size() < 5; i++) step();
      bus.req = '0;
      hold_mask = '0;
      wait_idle(40);
      for (int k = 0; k < 5; k++) begin
         tests++;
         if (k >= gnt_log.size() || gnt_log[k] != k % N) begin
            fails++; $display("FAIL rr_order[%0d]: got %0d, required %0d", k, (k < gnt_log.size()) ? gnt_log[k] : -1, k % N);
         end
      end
   endtask

   task automatic test_alternate();
      int want[4] = '{1, 3, 1, 3};
      gnt_log.delete();
      for (int i = 0; i < N; i++) begin
         bus.opa[i*W +: W] = W'($urandom_range(0, 63));
         bus.opb[i*W +: W] = W'($urandom_range(0, 63));
      end
      hold_mask = 4'b1010;
      bus.req = 4'b1010;
      for (int i = 0; i < 100 && gnt_log.size() < 4; i++) step();
      bus.req = '0;
      hold_mask = '0;
      wait_idle(40);
      for (int k = 0; k < 4; k++) begin
         tests++;
         if (k >= gnt_log.size() || gnt_log[k] != want[k]) begin
            fails++; $display("FAIL alt_order[%0d]: got %0d, required %0d", k, (k < gnt_log.size()) ? gnt_log[k] : -1, want[k]);
         end
      end
   endtask

   task automatic test_backpressure();
      bus.rsp_ready = 1'b0;
      start_add(0, 6'd10, 6'd7);
      wait_gnt(10);
      bus.req[0] = 1'b1;
      for (int i = 0; i < 20 && !s_valid; i++) step();
      for (int i = 0; i < 5; i++) begin
         step();
         tests++;
         if (s_gnt !== 4'b0000 || s_fa !== 3'b000 || s_valid !== 1'b1 ||
             {s_id, s_sum, s_cout, s_zero} !== {2'd0, 6'd17, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL stall[%0d]: gnt=%b fa=%b valid=%b id=%0d sum=%0d cout=%b zero=%b, required 0000/000/1/0/17/0/0",
                     i, s_gnt, s_fa, s_valid, s_id, s_sum, s_cout, s_zero);
         end
      end
      bus.rsp_ready = 1'b1;
      step();
      step();
      tests++;
      if (s_gnt !== 4'b0001) begin fails++; $display("FAIL stall_regrant: got %b, required 0001", s_gnt); end
      wait_idle(30);
   endtask

   task automatic test_reset_mid();
      start_add(1, 6'd5, 6'd3);
      wait_gnt(10);
      step();
      step();
      tests++;
      if (dbg_state !== 2'd1) begin fails++; $display("FAIL mid_state: got %0d, required 1", dbg_state); end
      rstn = 1'b0;
      #1;
      tests++;
      if ({busy, bus.rsp_valid, bus.gnt, fa_a, fa_b, fa_cin} !== '0 ||
          {bus.rsp_id, bus.rsp_sum, bus.rsp_cout, bus.rsp_zero} !== '0) begin
         fails++;
         $display("FAIL mid_reset_outputs: busy=%b valid=%b gnt=%b fa=%b rsp=%h, required all 0",
                  busy, bus.rsp_valid, bus.gnt, {fa_a, fa_b, fa_cin}, {bus.rsp_id, bus.rsp_sum, bus.rsp_cout, bus.rsp_zero});
      end
      exp_q.delete();
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;
      start_add(3, 6'd1, 6'd1);
      wait_rsp(30);
      tests++;
      if (last_rsp !== {2'd3, 6'd2, 1'b0, 1'b0}) begin fails++; $display("FAIL post_reset_rsp: got %h, required %h", last_rsp, {2'd3, 6'd2, 1'b0, 1'b0}); end
      wait_idle(20);
   endtask

   initial begin
      bus.req = '0;
      bus.opa = '0;
      bus.opb = '0;
      bus.rsp_ready = 1'b1;
      test_reset();
      test_basic();
      test_carry_zero();
      test_round_robin();
      test_alternate();
      test_backpressure();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
